// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment display.
// Segment patterns are active-high {g,f,e,d,c,b,a}; pin polarity is applied by the driver.
package display_pkg;

    typedef enum logic [1:0] {
        LEFT_ON  = 2'd0,
        DEAD_L2R = 2'd1,
        RIGHT_ON = 2'd2,
        DEAD_R2L = 2'd3
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 15 is leftmost: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return HEX_SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/dual_seven_seg_driver_if.sv
// Digit-load and display-pin bundle between the keypad path and the display driver.
interface dual_seven_seg_driver_if;
    logic [3:0] left_digit;
    logic [3:0] right_digit;
    logic       load;
    logic [6:0] seg;
    logic [1:0] anode;
    logic       frame_done;

    modport master (
        output left_digit, right_digit, load,
        input  seg, anode, frame_done
    );

    modport slave (
        input  left_digit, right_digit, load,
        output seg, anode, frame_done
    );
endinterface

// File: rtl/seven_seg_encoder.sv
// Combinational hex digit to active-high 7-segment pattern.
module seven_seg_encoder
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_ah
);
    assign seg_ah = hex_to_seg(hex);
endmodule

// File: rtl/dual_seven_seg_driver.sv
// Two-digit time-multiplexed 7-segment driver with blanking between digits.
// New digits are staged in pending registers and only reach the display at frame start.
module dual_seven_seg_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV      = 48000,
    parameter int DEAD_CYCLES      = 480,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    dual_seven_seg_driver_if.slave   disp
);
    localparam int MAX_N = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNT_W = $clog2(MAX_N);

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    localparam logic [1:0] ANODE_OFF   = ANODE_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [1:0] ANODE_LEFT  = ANODE_ACTIVE_LOW ? 2'b01 : 2'b10;
    localparam logic [1:0] ANODE_RIGHT = ANODE_ACTIVE_LOW ? 2'b10 : 2'b01;
    localparam logic [6:0] SEG_MASK    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    disp_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last;
    logic             frame_start;

    logic [3:0] shadow_left, shadow_right;
    logic [3:0] shadow_left_nxt, shadow_right_nxt;
    logic [3:0] pend_left, pend_right;
    logic       pend_valid;

    logic [3:0] enc_in;
    logic [6:0] enc_seg;

    logic [1:0] anode_nxt, anode_q;
    logic [6:0] seg_nxt, seg_q;
    logic       frame_done_nxt, frame_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DEAD_R2L;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        last      = (state == LEFT_ON || state == RIGHT_ON) ? (cnt == ON_LAST)
                                                            : (cnt == DEAD_LAST);
        if (last) begin
            cnt_nxt = '0;
            case (state)
                LEFT_ON:  state_nxt = DEAD_L2R;
                DEAD_L2R: state_nxt = RIGHT_ON;
                RIGHT_ON: state_nxt = DEAD_R2L;
                DEAD_R2L: state_nxt = LEFT_ON;
                default:  state_nxt = DEAD_R2L;
            endcase
        end
    end

    assign frame_start = (state == DEAD_R2L) && last;

    // A load on the frame-start edge takes priority over anything already pending.
    always_comb begin
        shadow_left_nxt  = shadow_left;
        shadow_right_nxt = shadow_right;
        if (frame_start) begin
            if (disp.load) begin
                shadow_left_nxt  = disp.left_digit;
                shadow_right_nxt = disp.right_digit;
            end else if (pend_valid) begin
                shadow_left_nxt  = pend_left;
                shadow_right_nxt = pend_right;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_left  <= '0;
            shadow_right <= '0;
            pend_left    <= '0;
            pend_right   <= '0;
            pend_valid   <= 1'b0;
        end else begin
            shadow_left  <= shadow_left_nxt;
            shadow_right <= shadow_right_nxt;
            if (disp.load) begin
                pend_left  <= disp.left_digit;
                pend_right <= disp.right_digit;
            end
            if (frame_start)
                pend_valid <= 1'b0;
            else if (disp.load)
                pend_valid <= 1'b1;
        end
    end

    assign enc_in = (state_nxt == RIGHT_ON) ? shadow_right_nxt : shadow_left_nxt;

    seven_seg_encoder u_enc (
        .hex    (enc_in),
        .seg_ah (enc_seg)
    );

    // Pins are derived from the next state so anode and seg switch on the same edge.
    always_comb begin
        anode_nxt      = ANODE_OFF;
        seg_nxt        = SEG_BLANK ^ SEG_MASK;
        frame_done_nxt = frame_start;
        case (state_nxt)
            LEFT_ON: begin
                anode_nxt = ANODE_LEFT;
                seg_nxt   = enc_seg ^ SEG_MASK;
            end
            RIGHT_ON: begin
                anode_nxt = ANODE_RIGHT;
                seg_nxt   = enc_seg ^ SEG_MASK;
            end
            default: begin
                anode_nxt = ANODE_OFF;
                seg_nxt   = SEG_BLANK ^ SEG_MASK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_BLANK ^ SEG_MASK;
            frame_done_q <= 1'b0;
        end else begin
            anode_q      <= anode_nxt;
            seg_q        <= seg_nxt;
            frame_done_q <= frame_done_nxt;
        end
    end

    assign disp.anode      = anode_q;
    assign disp.seg        = seg_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_dual_seven_seg_driver.sv
// Self-checking bench: frame-position reference model plus directed and table-driven sequences.
module tb_dual_seven_seg_driver;

    localparam int RD     = 8;
    localparam int DC     = 2;
    localparam int FRAME  = 2 * (RD + DC);
    localparam int POS_RR = RD + DC + RD;   // first DEAD_R2L position; reset lands here

    logic clk = 1'b0;
    logic reset = 1'b1;

    dual_seven_seg_driver_if dif ();

    dual_seven_seg_driver #(
        .REFRESH_DIV      (RD),
        .DEAD_CYCLES      (DC),
        .SEG_ACTIVE_LOW   (1'b1),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (dif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: display position within a frame of FRAME cycles.
    logic [6:0] enc_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         m_pos = POS_RR;
    logic [3:0] m_shl = '0, m_shr = '0, m_pl = '0, m_pr = '0;
    bit         m_pv = 1'b0;
    logic [1:0] m_an = 2'b11;
    logic [6:0] m_seg = 7'h7F;
    logic       m_fd = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pos = POS_RR;
            m_shl = '0; m_shr = '0; m_pl = '0; m_pr = '0; m_pv = 1'b0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) begin
                if (dif.load) begin
                    m_shl = dif.left_digit; m_shr = dif.right_digit;
                end else if (m_pv) begin
                    m_shl = m_pl; m_shr = m_pr;
                end
                m_pv = 1'b0;
            end else if (dif.load) begin
                m_pl = dif.left_digit; m_pr = dif.right_digit; m_pv = 1'b1;
            end
        end
        m_fd = !reset && (m_pos == 0);
        if (reset || (m_pos >= RD && m_pos < RD + DC) || m_pos >= POS_RR) begin
            m_an = 2'b11; m_seg = 7'h7F;
        end else if (m_pos < RD) begin
            m_an = 2'b01; m_seg = ~enc_ah[m_shl];
        end else begin
            m_an = 2'b10; m_seg = ~enc_ah[m_shr];
        end
    end

    always @(negedge clk) begin
        chk("mon_anode", 32'(dif.anode), 32'(m_an));
        chk("mon_seg", 32'(dif.seg), 32'(m_seg));
        chk("mon_frame_done", 32'(dif.frame_done), 32'(m_fd));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] l, input logic [3:0] r);
        dif.left_digit = l; dif.right_digit = r; dif.load = 1'b1;
        @(negedge clk);
        dif.load = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (m_pos != p) begin
            checks++;
            failures++;
            $display("FAIL wait_pos: position %0d not reached, at %0d", p, m_pos);
        end
    endtask

    typedef struct {
        logic [3:0] l;
        logic [3:0] r;
        logic [6:0] exp_l;
        logic [6:0] exp_r;
    } vec_t;

    vec_t vecs [16];
    logic [6:0] al_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial begin
        int dead;
        int period;
        for (int i = 0; i < 16; i++)
            vecs[i] = '{l: 4'(i), r: 4'(15 - i), exp_l: al_tab[i], exp_r: al_tab[15 - i]};

        dif.left_digit = '0; dif.right_digit = '0; dif.load = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_anode", 32'(dif.anode), 32'h3);
        chk("rst_seg", 32'(dif.seg), 32'h7F);
        chk("rst_fd", 32'(dif.frame_done), 32'h0);

        reset = 1'b0;
        tick();
        chk("fd_not_yet", 32'(dif.frame_done), 32'h0);
        tick();
        chk("first_fd", 32'(dif.frame_done), 32'h1);
        chk("first_anode", 32'(dif.anode), 32'h1);
        chk("first_seg", 32'(dif.seg), 32'h40);

        dead = 0; period = -1;
        for (int i = 1; i <= FRAME; i++) begin
            tick();
            if (dif.anode == 2'b11) dead++;
            if (dif.frame_done && period < 0) period = i;
        end
        chk("dead_cycles_per_frame", 32'(dead), 32'(2 * DC));
        chk("frame_period", 32'(period), 32'(FRAME));

        // Load during RIGHT_ON: current frame keeps old digits.
        wait_pos(12);
        do_load(4'h4, 4'hA);
        chk("midload_cur_right", 32'(dif.seg), 32'h40);
        wait_pos(0);
        chk("midload_left", 32'(dif.seg), 32'h19);
        wait_pos(10);
        chk("midload_right", 32'(dif.seg), 32'h08);

        // Several loads in one frame: last one wins.
        wait_pos(1);
        do_load(4'h1, 4'h2);
        tick();
        do_load(4'h3, 4'h4);
        wait_pos(15);
        do_load(4'h5, 4'h6);
        wait_pos(0);
        chk("multi_left", 32'(dif.seg), 32'h12);
        wait_pos(10);
        chk("multi_right", 32'(dif.seg), 32'h02);

        // Load sampled on the frame-start edge bypasses straight into the display.
        wait_pos(FRAME - 1);
        do_load(4'hF, 4'h0);
        chk("bypass_fd", 32'(dif.frame_done), 32'h1);
        chk("bypass_left", 32'(dif.seg), 32'h0E);
        chk("bypass_pend_clear", 32'(dut.pend_valid), 32'h0);
        wait_pos(10);
        chk("bypass_right", 32'(dif.seg), 32'h40);

        for (int i = 0; i < 16; i++) begin
            wait_pos(12);
            do_load(vecs[i].l, vecs[i].r);
            wait_pos(0);
            chk($sformatf("sweep_left_%0d", i), 32'(dif.seg), 32'(vecs[i].exp_l));
            wait_pos(10);
            chk($sformatf("sweep_right_%0d", i), 32'(dif.seg), 32'(vecs[i].exp_r));
        end

        // Reset during RIGHT_ON discards a pending load.
        wait_pos(12);
        do_load(4'h7, 4'h7);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_anode", 32'(dif.anode), 32'h3);
        chk("midrst_seg", 32'(dif.seg), 32'h7F);
        chk("midrst_shadow", 32'({dut.shadow_left, dut.shadow_right}), 32'h0);
        chk("midrst_pend", 32'(dut.pend_valid), 32'h0);
        reset = 1'b0;
        wait_pos(0);
        chk("postrst_left", 32'(dif.seg), 32'h40);
        wait_pos(10);
        chk("postrst_right", 32'(dif.seg), 32'h40);

        for (int i = 0; i < 1000; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            dif.load = ($urandom_range(0, 3) == 0);
            dif.left_digit = 4'($urandom_range(0, 15));
            dif.right_digit = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0; dif.load = 1'b0;
        repeat (FRAME) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
